// File: rtl/fetch_unit.sv
// Instruction fetch front end: walks a PC through a combinational instruction
// memory and buffers {pc, instr} pairs in a small FIFO ahead of decode.
// Redirects from execute flush the FIFO and reload from the new target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready
);

    // Pointer and occupancy widths for the legal depth range 2..4.
    localparam int PW = (QDEPTH > 2) ? 2 : 1;
    localparam int CW = (QDEPTH > 3) ? 3 : 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(QDEPTH - 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   pc_mem_q    [QDEPTH];
    logic [31:0]   pc_mem_d    [QDEPTH];
    logic [31:0]   instr_mem_q [QDEPTH];
    logic [31:0]   instr_mem_d [QDEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic deq;
    logic enq;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + 1'b1;
    endfunction

    assign imem_addr = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem_q[rd_ptr_q];
    assign out_instr = instr_mem_q[rd_ptr_q];

    // Next-state: handshake, fetch/enqueue, redirect flush (redirect wins).
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        deq = out_valid && out_ready;
        enq = !redirect_valid && ((count_q != DEPTH_C) || deq);

        if (redirect_valid) begin
            // A same-edge handshake is still a delivery; everything else is dropped.
            fetch_pc_d = {redirect_target[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (enq) begin
                pc_mem_d[wr_ptr_q]    = fetch_pc_q;
                instr_mem_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d              = ptr_inc(wr_ptr_q);
                fetch_pc_d            = fetch_pc_q + 32'd4;
            end
            if (deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers with asynchronous clear of PC, pointers and all entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            pc_mem_q    <= pc_mem_d;
            instr_mem_q <= instr_mem_d;
        end
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset (bits [1:0] SHALL be 00).
REQ-002 Parameter: QDEPTH, default 2, fetch queue depth in entries (legal values 2..4).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_addr  output  32  fetch address to the combinational instruction memory.
REQ-006 imem_rdata  input  32  instruction word at imem_addr, valid in the same cycle.
REQ-007 redirect_valid  input  1  branch/jump redirect request from the execute stage.
REQ-008 redirect_target  input  32  new fetch address when redirect_valid=1.
REQ-009 out_valid  output  1  queue head holds a valid instruction.
REQ-010 out_instr  output  32  instruction at the queue head.
REQ-011 out_pc  output  32  PC of the queue head.
REQ-012 out_ready  input  1  decode accepts the head this cycle.

Function
REQ-013 State SHALL consist of: fetch_pc register; QDEPTH-entry FIFO of {pc, instr}; occupancy count 0..QDEPTH.
REQ-014 imem_addr SHALL equal fetch_pc combinationally.
REQ-015 A dequeue SHALL occur on any edge where out_valid=1 and out_ready=1.
REQ-016 An enqueue SHALL occur on any edge where redirect_valid=0 and (count<QDEPTH or a dequeue occurs); the pushed entry SHALL be {fetch_pc, imem_rdata}.
REQ-017 On enqueue, fetch_pc SHALL advance by 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-018 With no enqueue and no redirect, fetch_pc SHALL hold.
REQ-019 Simultaneous enqueue and dequeue SHALL leave count unchanged, including when the FIFO is full.
REQ-020 out_valid SHALL be (count!=0); out_instr and out_pc SHALL come from the head entry, with no combinational path from imem_rdata.
REQ-021 Redirect (redirect_valid=1) SHALL take priority: count<=0, fetch_pc<={redirect_target[31:2],2'b00}, no enqueue that edge.
REQ-022 A handshake on the redirect edge SHALL count as delivered to decode; the remaining entries SHALL be discarded.
REQ-023 Redirect while empty or full SHALL behave identically (flush + reload).
REQ-024 Latency: an instruction SHALL be presented on out_valid one cycle after fetch; sustained throughput SHALL be 1 instr/cycle while out_ready=1.
REQ-025 out_ready=0 for any number of cycles SHALL hold out_instr and out_pc stable with out_valid=1, with no loss and no duplication.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) set fetch_pc=RESET_PC, count=0, out_valid=0, out_instr=0, out_pc=0, and clear all FIFO entries.
REQ-027 Reset asserted mid-operation SHALL discard all queued entries and any pending redirect.
REQ-028 The first enqueue SHALL occur on the first rising edge with rst_n=1 and SHALL fetch address RESET_PC.

Verification
Bench memory: 0x0=FFC4A303, 0x4=0064A423, 0x8=0062E233, 0xC=FE420AE3.
REQ-029 Streaming: reset release, out_ready=1 -> out_pc/out_instr = 0/FFC4A303, 4/0064A423, 8/0062E233, C/FE420AE3 on consecutive cycles after 1-cycle latency.
REQ-030 Backpressure: out_ready=0 for 5 cycles -> count=2, fetch_pc=0x8, head stays 0/FFC4A303; release -> 0, 4, 8 in order with no gaps.
REQ-031 Redirect: redirect_valid=1, target=0x0000_0006 with FIFO full -> next cycle out_valid=0, imem_addr=0x4; following cycle out_pc=0x4, out_instr=0064A423.
REQ-032 Redirect with handshake on the same edge -> head counted delivered exactly once; no stale PC appears afterward.
REQ-033 Wrap: redirect to 0xFFFF_FFFC -> entry pc=0xFFFF_FFFC, next fetch at 0x0000_0000.
REQ-034 Async reset: assert rst_n=0 between edges with FIFO full -> out_valid=0 before the next edge; restart fetches from RESET_PC.
